fetch_stage: RTL and testbench

- Instruction-fetch stage. Owns the program counter and drives the synchronous instruction ROM; fills the IF/ID pipeline register consumed by decode.
- Takes the redirect target from the branch-offset adder, a taken flag from branch resolution, and a stall from load-use hazard detection.
- Contains a 1-entry skid buffer so a ROM word returning during a stall is never lost.

---
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, synchronous ROM drive, 1-entry skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module fetch_stage #(
  parameter int unsigned     PC_W     = 10,
  parameter int unsigned     INSN_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [PC_W-1:0]   iBranchTarget,
  output logic [PC_W-1:0]   oIMemAddr,
  output logic              oIMemRead,
  input  logic [INSN_W-1:0] iIMemData,
  output logic [PC_W-1:0]   oPCPlus1,
  output logic [INSN_W-1:0] oInstr,
  output logic [PC_W-1:0]   oInstrPC,
  output logic              oInstrValid,
  output logic [1:0]        oState
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       oFetchCount,
  output logic [15:0]       oFlushCount
`endif
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e              state;
  logic [PC_W-1:0]     pc;
  logic                in_flight;
  logic [PC_W-1:0]     in_flight_pc;
  logic                skid_valid;
  logic [INSN_W-1:0]   skid_instr;
  logic [PC_W-1:0]     skid_pc;
  logic [INSN_W-1:0]   instr;
  logic [PC_W-1:0]     instr_pc;
  logic                instr_valid;
  logic                run;

  // A read issues only in a plain run cycle: no reset, branch, boot or stall.
  assign run         = !Reset && !iBranchTaken && (state != StBoot) && !iStall;
  assign oIMemRead   = run;
  assign oIMemAddr   = pc;
  assign oPCPlus1    = pc + PC_W'(1);
  assign oInstr      = instr;
  assign oInstrPC    = instr_pc;
  assign oInstrValid = instr_valid;
  assign oState      = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= StBoot;
      pc           <= RESET_PC;
      in_flight    <= 1'b0;
      in_flight_pc <= '0;
      skid_valid   <= 1'b0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
    end else if (iBranchTaken) begin
      pc          <= iBranchTarget;
      in_flight   <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
      state       <= StRun;
    end else if (state == StBoot) begin
      state <= StRun;
    end else if (iStall) begin
      // Park the word returning this cycle; no new read issues while stalled.
      if (in_flight) begin
        skid_valid <= 1'b1;
        skid_instr <= iIMemData;
        skid_pc    <= in_flight_pc;
      end
      in_flight <= 1'b0;
      state     <= StHold;
    end else begin
      pc           <= oPCPlus1;
      in_flight    <= 1'b1;
      in_flight_pc <= pc;
      state        <= StRun;
      if (skid_valid) begin
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
        instr_valid <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (in_flight) begin
        instr       <= iIMemData;
        instr_pc    <= in_flight_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oFetchCount <= '0;
      oFlushCount <= '0;
    end else begin
      if (run && (oFetchCount != 16'hFFFF)) oFetchCount <= oFetchCount + 16'd1;
      if (iBranchTaken && (instr_valid || in_flight) && (oFlushCount != 16'hFFFF)) begin
        oFlushCount <= oFlushCount + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Stalls never issue reads, so the skid and an in-flight read cannot meet in a run cycle.
  skid_excl_a : assert property (@(posedge Clock) disable iff (Reset)
                                 run |-> !(skid_valid && in_flight));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/branch/reset
// traffic compared against a queue-based fetch-stream model.
module tb_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset, iStall, iBranchTaken;
  logic [9:0]  iBranchTarget, oIMemAddr, oPCPlus1, oInstrPC;
  logic        oIMemRead, oInstrValid;
  logic [15:0] iIMemData, oInstr;
  logic [1:0]  oState;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] oFetchCount, oFlushCount;
`endif

  fetch_stage dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .oIMemAddr(oIMemAddr), .oIMemRead(oIMemRead),
    .iIMemData(iIMemData), .oPCPlus1(oPCPlus1), .oInstr(oInstr), .oInstrPC(oInstrPC),
    .oInstrValid(oInstrValid), .oState(oState)
`ifdef FETCH_PERF_CNT_EN
    , .oFetchCount(oFetchCount), .oFlushCount(oFlushCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM: word appears the cycle after the read strobe and holds otherwise.
  logic [15:0] rom [1024];
  logic [15:0] rom_data = '0;
  assign iIMemData = rom_data;
  always @(posedge Clock) if (oIMemRead) rom_data <= rom[oIMemAddr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC, FIFO of fetched-but-undelivered addresses, IF/ID contents.
  logic [9:0]  m_pc = '0;
  logic [9:0]  m_q [$];
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = '0;
  logic [9:0]  m_ipc = '0;
  int          m_state = 0;

  logic        exp_read, obs_read;
  logic [9:0]  exp_addr, obs_addr, exp_plus1, obs_plus1;

  task automatic model_step(input logic rst, input logic br, input logic st,
                            input logic [9:0] tgt);
    if (rst) begin
      m_pc = '0; m_q.delete(); m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_state = 0;
    end else if (br) begin
      m_q.delete(); m_valid = 1'b0; m_pc = tgt; m_state = 1;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (st) begin
      m_state = 2;
    end else begin
      if (m_q.size() > 0) begin
        m_ipc = m_q.pop_front(); m_instr = rom[m_ipc]; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 10'd1;
      m_state = 1;
    end
  endtask

  // One clock: apply inputs, sample combinational outputs at negedge, advance past the edge.
  task automatic drive(input logic rst, input logic br, input logic st, input logic [9:0] tgt);
    Reset = rst; iBranchTaken = br; iStall = st; iBranchTarget = tgt;
    exp_read  = !rst && !br && (m_state != 0) && !st;
    exp_addr  = m_pc;
    exp_plus1 = m_pc + 10'd1;
    @(negedge Clock);
    obs_read = oIMemRead; obs_addr = oIMemAddr; obs_plus1 = oPCPlus1;
    @(posedge Clock);
    model_step(rst, br, st, tgt);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", obs_read); end
    n_checks++; if (oInstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", oInstrValid); end
    n_checks++; if (oInstr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", oInstr); end
    n_checks++; if (oInstrPC !== 10'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", oInstrPC); end
    n_checks++; if (oState !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", oState); end
    n_checks++; if (oIMemAddr !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", oIMemAddr); end
  endtask

  task automatic test_boot_run();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      if (k == 1) begin
        n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL boot_read: got %b want 0", obs_read); end
      end
      if (k < 3) begin
        n_checks++; if (oInstrValid !== 1'b0) begin n_fail++; $display("FAIL boot_valid k=%0d: got %b want 0", k, oInstrValid); end
      end else begin
        n_checks++;
        if (oInstrValid !== 1'b1 || oInstrPC !== 10'(k - 3) || oInstr !== 16'(16'h100 + k - 3)) begin
          n_fail++;
          $display("FAIL run_seq k=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                   k, oInstrValid, oInstrPC, oInstr, 10'(k - 3), 16'(16'h100 + k - 3));
        end
      end
    end
  endtask

  task automatic test_stall();
    test_reset();
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, '0);
      n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL stall_read: got %b want 0", obs_read); end
      n_checks++;
      if (oInstrPC !== 10'd4 || oInstrValid !== 1'b1 || oState !== 2'd2) begin
        n_fail++; $display("FAIL stall_hold: got pc=%h v=%b st=%0d want pc=4 v=1 st=2", oInstrPC, oInstrValid, oState);
      end
    end
    for (int k = 5; k <= 7; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (oInstrPC !== 10'(k) || oInstr !== 16'(16'h100 + k) || oInstrValid !== 1'b1) begin
        n_fail++; $display("FAIL stall_release: got pc=%h i=%h v=%b want pc=%h", oInstrPC, oInstr, oInstrValid, 10'(k));
      end
    end
  endtask

  task automatic test_branch();
    for (int g = 0; g < 50 && m_pc != 10'd12; g++) drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (oIMemAddr !== 10'd12) begin n_fail++; $display("FAIL branch_setup: got %h want 00c", oIMemAddr); end
    drive(1'b0, 1'b1, 1'b0, 10'd40);
    n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL branch_read: got %b want 0", obs_read); end
    n_checks++; if (oInstrValid !== 1'b0) begin n_fail++; $display("FAIL branch_bubble1: got %b want 0", oInstrValid); end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (oInstrValid !== 1'b0) begin n_fail++; $display("FAIL branch_bubble2: got %b want 0", oInstrValid); end
    for (int k = 40; k <= 42; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (oInstrValid !== 1'b1 || oInstrPC !== 10'(k) || oInstr !== 16'(16'h100 + k)) begin
        n_fail++; $display("FAIL branch_target: got v=%b pc=%h want v=1 pc=%h", oInstrValid, oInstrPC, 10'(k));
      end
    end
  endtask

  task automatic test_branch_stall();
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b1, 10'd40);
    n_checks++;
    if (obs_read !== 1'b0 || oInstrValid !== 1'b0 || oState !== 2'd1) begin
      n_fail++; $display("FAIL br_stall: got rd=%b v=%b st=%0d want 0 0 1", obs_read, oInstrValid, oState);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (oInstrValid !== 1'b0) begin n_fail++; $display("FAIL br_stall_bubble: got %b want 0", oInstrValid); end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (oInstrValid !== 1'b1 || oInstrPC !== 10'd40) begin
      n_fail++; $display("FAIL br_stall_target: got v=%b pc=%h want v=1 pc=028", oInstrValid, oInstrPC);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] want [3];
    want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000;
    drive(1'b0, 1'b1, 1'b0, 10'h3FE);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (obs_addr !== 10'h3FF || obs_plus1 !== 10'h000) begin
      n_fail++; $display("FAIL wrap_plus1: got addr=%h p1=%h want 3ff 000", obs_addr, obs_plus1);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        n_checks++; if (obs_addr !== 10'h000) begin n_fail++; $display("FAIL wrap_addr: got %h want 000", obs_addr); end
      end
      n_checks++;
      if (oInstrValid !== 1'b1 || oInstrPC !== want[k]) begin
        n_fail++; $display("FAIL wrap_seq: got v=%b pc=%h want pc=%h", oInstrValid, oInstrPC, want[k]);
      end
      drive(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b1, '0);
    n_checks++;
    if (oInstrValid !== 1'b0 || oInstr !== 16'h0 || oInstrPC !== 10'h0 || oState !== 2'd0 || oIMemAddr !== 10'h0) begin
      n_fail++; $display("FAIL rst_stall: got v=%b i=%h pc=%h st=%0d a=%h want all 0",
                         oInstrValid, oInstr, oInstrPC, oState, oIMemAddr);
    end
    test_boot_run();
  endtask

  task automatic test_random();
    logic rst, br, st;
    logic [9:0] tgt;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      tgt = 10'($urandom);
      drive(rst, br, st, tgt);
      n_checks++; if (obs_read !== exp_read) begin n_fail++; $display("FAIL rnd_read n=%0d: got %b want %b", n, obs_read, exp_read); end
      n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr n=%0d: got %h want %h", n, obs_addr, exp_addr); end
      n_checks++; if (obs_plus1 !== exp_plus1) begin n_fail++; $display("FAIL rnd_plus1 n=%0d: got %h want %h", n, obs_plus1, exp_plus1); end
      n_checks++; if (oState !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state n=%0d: got %0d want %0d", n, oState, m_state); end
      n_checks++; if (oInstrValid !== m_valid) begin n_fail++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, oInstrValid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if (oInstr !== m_instr || oInstrPC !== m_ipc) begin
          n_fail++; $display("FAIL rnd_ifid n=%0d: got i=%h pc=%h want i=%h pc=%h", n, oInstr, oInstrPC, m_instr, m_ipc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'(i + 16'h100);
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    @(posedge Clock);
    #1;
    test_reset();
    test_boot_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
